debounce_multi: RTL and testbench

- Next-generation multi-channel input conditioner for the keypad and button front end; sits between raw pad inputs and the key decoder.
- Per-channel saturating integrator with hysteresis, clocked by a shared sample prescaler.
- Registered per-channel press and release pulses, per-channel auto-repeat, selectable input polarity, synchronous clear.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_chan.sv | 123 ++++++++++++
 rtl/debounce_multi.sv | 97 +++++++++
 tb/tb_debounce_multi.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_pkg : shared sizing helpers and parameter limits for debounce_multi
// Revision     : 1.0
// ----------------------------------------------------------------------------
package debounce_pkg;

  localparam int MIN_TICKS  = 2;
  localparam int MIN_STABLE = 2;
  localparam int MIN_REPEAT = 1;

  function automatic int calc_ticks(input longint clk_freq, input longint sample_us);
    return int'((clk_freq / longint'(1_000_000)) * sample_us);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_chan : one channel - saturating integrator, hysteresis, edge pulses
//                 and auto-repeat scheduler
// Revision      : 1.0
// ----------------------------------------------------------------------------
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = 8,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic s_i,
  input  logic tick_i,
  input  logic clear_i,
  output logic debounced_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int            CW       = cnt_w(STABLE_SAMPLES);
  localparam logic [CW-1:0] C_FULL   = CW'(STABLE_SAMPLES);
  localparam int            HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            HW       = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (s_i && (cnt_q != C_FULL)) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!s_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    // The level only flips at the integrator rails, giving the hysteresis band
    deb_d = deb_q;
    if (clear_i) begin
      deb_d = 1'b0;
    end else if (cnt_d == C_FULL) begin
      deb_d = 1'b1;
    end else if (cnt_d == '0) begin
      deb_d = 1'b0;
    end

    press_d   = deb_d & ~deb_q;
    release_d = ~clear_i & deb_q & ~deb_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign debounced_o = deb_q;
  assign press_o     = press_q;
  assign release_o   = release_q;

  if (REPEAT_EN != 0) begin : g_repeat
    logic [HW-1:0] hold_q, hold_d, limit;
    logic          first_q, first_d;
    logic          rep_q, rep_d;

    always_comb begin
      hold_d  = hold_q;
      first_d = first_q;
      rep_d   = 1'b0;
      limit   = first_q ? HW'(REPEAT_DELAY) : HW'(REPEAT_PERIOD);
      // Schedule restarts unless the key was already held and stays held
      if (clear_i || !deb_q || !deb_d) begin
        hold_d  = '0;
        first_d = 1'b1;
      end else if (tick_i) begin
        if ((hold_q + HW'(1)) == limit) begin
          hold_d  = '0;
          first_d = 1'b0;
          rep_d   = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_q  <= '0;
        first_q <= 1'b1;
        rep_q   <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        first_q <= first_d;
        rep_q   <= rep_d;
      end
    end

    assign repeat_o = rep_q;
  end else begin : g_no_repeat
    assign repeat_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_multi : multi-channel keypad/button conditioner - prescaler,
//                  synchronizers, polarity fix-up and per-channel debouncers
// Revision       : 1.0
// ----------------------------------------------------------------------------
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int SAMPLE_US      = 1000,
  parameter int STABLE_SAMPLES = 8,
  parameter int ACTIVE_LOW     = 0,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] debounced_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o,
  output logic [WIDTH-1:0] repeat_pulse_o,
  output logic             any_pressed_o
);

  localparam int               TICKS  = calc_ticks(CLK_FREQ, SAMPLE_US);
  localparam int               PW     = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [PW-1:0]    C_LAST = PW'(TICKS - 1);
  localparam logic [WIDTH-1:0] C_IDLE = {WIDTH{ACTIVE_LOW != 0}};

  if (TICKS < MIN_TICKS) begin : g_chk_ticks
    $error("debounce_multi: TICKS must be at least 2");
  end
  if (STABLE_SAMPLES < MIN_STABLE) begin : g_chk_stable
    $error("debounce_multi: STABLE_SAMPLES must be at least 2");
  end
  if ((REPEAT_DELAY < MIN_REPEAT) || (REPEAT_PERIOD < MIN_REPEAT)) begin : g_chk_repeat
    $error("debounce_multi: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] s;
  logic             any_q;

  assign tick = (presc_q == C_LAST);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (clear_i || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      sync1_q <= C_IDLE;
      sync2_q <= C_IDLE;
      any_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      any_q   <= |debounced_o;
    end
  end

  assign s             = sync2_q ^ C_IDLE;
  assign any_pressed_o = any_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .s_i        (s[i]),
      .tick_i     (tick),
      .clear_i    (clear_i),
      .debounced_o(debounced_o[i]),
      .press_o    (press_o[i]),
      .release_o  (release_o[i]),
      .repeat_o   (repeat_pulse_o[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_debounce_multi : scoreboard bench for debounce_multi, active-high and
//                     active-low instances driven side by side
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_debounce_multi;

  localparam int W     = 4;
  localparam int CLKF  = 1_000_000;
  localparam int SUS   = 10;
  localparam int TICKS = (CLKF / 1_000_000) * SUS;
  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int RP    = 3;

  typedef struct packed {
    logic [W-1:0] deb;
    logic [W-1:0] prs;
    logic [W-1:0] rel;
    logic [W-1:0] rep;
    logic         anyp;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] raw0  = '1;
  logic [W-1:0] raw1  = '1;
  logic [W-1:0] deb [2];
  logic [W-1:0] prs [2];
  logic [W-1:0] rel [2];
  logic [W-1:0] rep [2];
  logic         anyp[2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .WIDTH(W), .CLK_FREQ(CLKF), .SAMPLE_US(SUS), .STABLE_SAMPLES(N),
    .ACTIVE_LOW(0), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_hi (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .raw_i(raw0),
    .debounced_o(deb[0]), .press_o(prs[0]), .release_o(rel[0]),
    .repeat_pulse_o(rep[0]), .any_pressed_o(anyp[0])
  );

  debounce_multi #(
    .WIDTH(W), .CLK_FREQ(CLKF), .SAMPLE_US(SUS), .STABLE_SAMPLES(N),
    .ACTIVE_LOW(1), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_lo (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .raw_i(raw1),
    .debounced_o(deb[1]), .press_o(prs[1]), .release_o(rel[1]),
    .repeat_pulse_o(rep[1]), .any_pressed_o(anyp[1])
  );

  // Reference model: integrator value, level and "ticks held since press" per channel
  int           m_cnt [2][W];
  bit           m_deb [2][W];
  int           m_held[2][W];
  logic [W-1:0] m_s1[2];
  logic [W-1:0] m_s2[2];
  int           since;
  bit           m_tick;
  exp_t         sb0[$];
  exp_t         sb1[$];
  exp_t         e0, e1;

  function automatic logic [W-1:0] idle_of(input int k);
    logic [W-1:0] v;
    v = (k == 1) ? '1 : '0;
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < W; i++) begin
        m_cnt[k][i]  = 0;
        m_deb[k][i]  = 1'b0;
        m_held[k][i] = 0;
      end
      m_s1[k] = idle_of(k);
      m_s2[k] = idle_of(k);
    end
    since = 0;
  endfunction

  function automatic exp_t model_step(input int k, input logic [W-1:0] raw_now,
                                      input bit clr, input bit tk);
    exp_t         e;
    logic [W-1:0] s;
    bit           was;
    e = '0;
    s = m_s2[k] ^ idle_of(k);
    for (int i = 0; i < W; i++) e.anyp = e.anyp | m_deb[k][i];
    for (int i = 0; i < W; i++) begin
      was = m_deb[k][i];
      if (clr) begin
        m_cnt[k][i]  = 0;
        m_deb[k][i]  = 1'b0;
        m_held[k][i] = 0;
      end else begin
        if (tk) begin
          if (s[i] && m_cnt[k][i] < N) m_cnt[k][i]++;
          else if (!s[i] && m_cnt[k][i] > 0) m_cnt[k][i]--;
        end
        if (m_cnt[k][i] == N) m_deb[k][i] = 1'b1;
        else if (m_cnt[k][i] == 0) m_deb[k][i] = 1'b0;
        e.deb[i] = m_deb[k][i];
        e.prs[i] = m_deb[k][i] && !was;
        e.rel[i] = !m_deb[k][i] && was;
        if (!(was && m_deb[k][i])) begin
          m_held[k][i] = 0;
        end else if (tk) begin
          m_held[k][i]++;
          e.rep[i] = (m_held[k][i] >= RD) && (((m_held[k][i] - RD) % RP) == 0);
        end
      end
    end
    m_s2[k] = m_s1[k];
    m_s1[k] = raw_now;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
      sb0.push_back('0);
      sb1.push_back('0);
    end else begin
      m_tick = ((since % TICKS) == (TICKS - 1));
      sb0.push_back(model_step(0, raw0, clear, m_tick));
      sb1.push_back(model_step(1, raw1, clear, m_tick));
      since = clear ? 0 : since + 1;
    end
  end

  // Asynchronous reset clears outputs mid-cycle, so replace this cycle's expectation
  always @(negedge rst_n) begin
    model_reset();
    sb0.delete();
    sb1.delete();
    sb0.push_back('0);
    sb1.push_back('0);
  end

  task automatic compare(input int k, input exp_t e);
    exp_t got;
    got.deb  = deb[k];
    got.prs  = prs[k];
    got.rel  = rel[k];
    got.rep  = rep[k];
    got.anyp = anyp[k];
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL sb_dut%0d t=%0t got deb=%h prs=%h rel=%h rep=%h any=%b exp deb=%h prs=%h rel=%h rep=%h any=%b",
               k, $time, got.deb, got.prs, got.rel, got.rep, got.anyp,
               e.deb, e.prs, e.rel, e.rep, e.anyp);
    end
  endtask

  always @(negedge clk) begin
    if (sb0.size() > 0) begin
      e0 = sb0.pop_front();
      compare(0, e0);
    end
    if (sb1.size() > 0) begin
      e1 = sb1.pop_front();
      compare(1, e1);
    end
  end

  function automatic logic [W-1:0] get_sig(input int k, input int sel);
    case (sel)
      0:       return deb[k];
      1:       return prs[k];
      2:       return rel[k];
      default: return rep[k];
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    vectors++;
    if (got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi);
    end
  endtask

  // Counts falling edges until any masked bit of the selected output is high
  task automatic wait_sig(input string name, input int k, input int sel,
                          input logic [W-1:0] mask, input int budget, output int cyc);
    cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if ((get_sig(k, sel) & mask) != '0) begin
        cyc = c;
        break;
      end
    end
    if (cyc == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout got=none exp=event within %0d cycles", name, budget);
      cyc = -1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int dur;

    // Reset with channels asserted on the active-high instance
    raw0 = '1; raw1 = '1; rst_n = 1'b0;
    step(5);
    rst_n = 1'b1;
    wait_sig("t1_press_latency", 0, 1, 4'hF, 100, cyc);
    check_range("t1_press_latency", cyc, 2 + (N - 1) * TICKS, 2 + N * TICKS);
    check_eq("t1_press_all", prs[0], 4'hF);
    check_eq("t1_deb_all", deb[0], 4'hF);
    check_eq("t1_any_lags", {3'b0, anyp[0]}, 4'h0);
    @(negedge clk);
    check_eq("t1_any_rises", {3'b0, anyp[0]}, 4'h1);
    check_eq("t1_press_one_cycle", prs[0], 4'h0);

    step(1);
    raw0 = '0;
    step(60);

    // Bouncing channel 0
    for (int t = 0; t < 300 / 7; t++) begin
      raw0[0] = ~raw0[0];
      step(7);
    end
    raw0 = '0;
    step(60);

    // Held key with auto-repeat, then release
    raw0[1] = 1'b1;
    wait_sig("t3_press", 0, 1, 4'b0010, 80, cyc);
    wait_sig("t3_first_repeat", 0, 3, 4'b0010, 200, cyc);
    check_range("t3_first_repeat_delay", cyc, RD * TICKS, RD * TICKS);
    wait_sig("t3_next_repeat", 0, 3, 4'b0010, 100, cyc);
    check_range("t3_repeat_period", cyc, RP * TICKS, RP * TICKS);
    step(1);
    raw0[1] = 1'b0;
    wait_sig("t3_release", 0, 2, 4'b0010, 100, cyc);
    check_range("t3_release_latency", cyc, 2 + (N - 1) * TICKS, 2 + N * TICKS);
    step(60);

    // Active-low instance: a low pad is a press
    raw1[2] = 1'b0;
    wait_sig("t4_press_lo", 1, 1, 4'b0100, 80, cyc);
    check_eq("t4_press_lo", prs[1], 4'b0100);
    check_eq("t4_deb_lo", deb[1], 4'b0100);
    step(1);
    raw1 = '1;
    step(60);

    // Clear coincident with a sample tick
    raw0 = 4'b0101;
    step(60);
    check_eq("t5_deb_before_clear", deb[0], 4'b0101);
    while ((since % TICKS) != (TICKS - 1)) step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_eq("t5_deb_cleared", deb[0], 4'h0);
    check_eq("t5_no_release", rel[0], 4'h0);
    raw0 = '0;
    step(60);

    // Simultaneous presses, then reset mid-integration
    raw0 = 4'b1001;
    wait_sig("t6_press", 0, 1, 4'b1001, 80, cyc);
    check_eq("t6_press_same_cycle", prs[0], 4'b1001);
    step(1);
    raw0 = 4'b0110;
    step(25);
    rst_n = 1'b0;
    #1;
    check_eq("t6_reset_deb", deb[0], 4'h0);
    step(3);
    rst_n = 1'b1;
    step(20);

    // Randomized activity on both instances
    for (int it = 0; it < 300; it++) begin
      raw0 = raw0 ^ W'($urandom_range(0, 15));
      raw1 = raw1 ^ W'($urandom_range(0, 15));
      dur  = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 200) : $urandom_range(1, 50);
      if ($urandom_range(0, 19) == 0) begin
        clear = 1'b1;
        step(1);
        clear = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(dur);
    end

    raw0 = '0;
    raw1 = '1;
    step(80);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
